// File: rtl/mch_tx_ctl.sv
// mch_tx_ctl: Manchester frame transmitter with a 14-byte frame buffer.
// A frame is 24 sync bits, 112 data bits (byte 0 first, MSB first) and a
// 34-bit-period idle-high guard. Each bit period is 50 clk.
// Optional feature macro: MCH_TX_CRC_EN. When it is defined, the host loads
// 13 bytes and data byte 13 is a serial CRC-8 (poly 0x07, init 0x00).
//
// Strobe protocol: tx_wr and tx_start are single-cycle strobes sampled on
// the rising clk edge. There is no ready signal. tx_wr is taken only in
// IDLE with tx_full low. tx_start is taken only in IDLE with tx_full high,
// and tx_full is sampled before any write in that same cycle.
module mch_tx_ctl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    input  logic       tx_start,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txsd,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [5:0] BIT_LAST   = 6'd49;
    localparam logic [5:0] HALF       = 6'd25;
    localparam logic [6:0] SYNC_LAST  = 7'd23;
    localparam logic [6:0] DATA_LAST  = 7'd111;
    localparam logic [6:0] GUARD_LAST = 7'd33;
`ifdef MCH_TX_CRC_EN
    localparam logic [3:0] PAYLOAD_LEN   = 4'd13;
    localparam logic [6:0] CRC_FIRST_BIT = 7'd104;
`else
    localparam logic [3:0] PAYLOAD_LEN   = 4'd14;
`endif

    state_t     state, state_d;
    logic [5:0] cnt, cnt_d;
    logic [6:0] bit_idx, bit_d;
    logic [6:0] last_bit;
    logic [3:0] ptr;
    logic       done_d;
    logic       txsd_d;
    logic       level_bit;
    logic       data_bit_d;
    logic       wr_ok;
    logic       start_ok;
    logic [7:0] sel_byte;
    logic [7:0] buf_mem [0:13];

    assign tx_full   = (ptr == PAYLOAD_LEN);
    assign tx_busy   = (state != IDLE);
    assign dbg_state = state;
    assign wr_ok     = tx_wr && (state == IDLE) && !tx_full;
    assign start_ok  = tx_start && (state == IDLE) && tx_full;

    // Next-state logic: bit-period counter and per-state bit index
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        done_d  = 1'b0;
        case (state)
            SYNC:    last_bit = SYNC_LAST;
            DATA:    last_bit = DATA_LAST;
            default: last_bit = GUARD_LAST;
        endcase
        if (state == IDLE) begin
            if (start_ok) begin
                state_d = SYNC;
                cnt_d   = 6'd0;
                bit_d   = 7'd0;
            end
        end else if (cnt == BIT_LAST) begin
            cnt_d = 6'd0;
            if (bit_idx == last_bit) begin
                bit_d = 7'd0;
                case (state)
                    SYNC:    state_d = DATA;
                    DATA:    state_d = GUARD;
                    default: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end else begin
                bit_d = bit_idx + 7'd1;
            end
        end else begin
            cnt_d = cnt + 6'd1;
        end
    end

`ifdef MCH_TX_CRC_EN
    logic [7:0] crc, crc_d;
    logic [7:0] cur_byte;
    logic       cur_bit;
    logic       crc_fb;

    // Serial CRC over data bytes 0..12, one update at the end of each bit period
    always_comb begin
        cur_byte = buf_mem[bit_idx[6:3]];
        cur_bit  = cur_byte[3'd7 - bit_idx[2:0]];
        crc_fb   = crc[7] ^ cur_bit;
        crc_d    = crc;
        if (state == IDLE) begin
            crc_d = 8'h00;
        end else if (state == DATA && cnt == BIT_LAST && bit_idx < CRC_FIRST_BIT) begin
            crc_d = {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
        end
    end

    // CRC register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) crc <= 8'h00;
        else      crc <= crc_d;
    end
`endif

    // Line level for the upcoming cycle, derived from next-state values
    always_comb begin
        sel_byte   = buf_mem[bit_d[6:3]];
        data_bit_d = sel_byte[3'd7 - bit_d[2:0]];
`ifdef MCH_TX_CRC_EN
        if (bit_d >= CRC_FIRST_BIT) data_bit_d = crc_d[3'd7 - bit_d[2:0]];
`endif
        level_bit = (state_d == SYNC) ? bit_d[2] : data_bit_d;
        txsd_d    = 1'b1;
        if (state_d == SYNC || state_d == DATA)
            txsd_d = (cnt_d < HALF) ? level_bit : ~level_bit;
    end

    // Control state, write pointer and registered line output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            bit_idx <= 7'd0;
            ptr     <= 4'd0;
            txsd    <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            txsd    <= txsd_d;
            tx_done <= done_d;
            if (done_d)     ptr <= 4'd0;
            else if (wr_ok) ptr <= ptr + 4'd1;
        end
    end

    // Frame buffer: data only, no reset needed
    always_ff @(posedge clk) begin
        if (wr_ok) buf_mem[ptr] <= tx_data;
    end

endmodule
